// File: rtl/bk_sum_stage.sv
// Registered sum stage of the Brent-Kung adder: forms sum/cout/zero from the PG network
// and buffers results in a 2-entry skid buffer with valid/ready on both sides.
module bk_sum_stage #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   p_bit,
  input  logic [WIDTH:0]   g_grp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             occ, occ_nxt;
  logic             wr_ptr, rd_ptr;
  logic             in_ready_q;
  logic [CNT_W-1:0] op_cnt_q;

  logic [WIDTH-1:0] mem_sum  [2];
  logic             mem_cout [2];
  logic             mem_zero [2];
  logic [TAG_W-1:0] mem_tag  [2];

  logic             push, pop;
  logic [WIDTH-1:0] new_sum;
  logic             new_zero;
  logic             unused_p0;

  // p_bit[0] has no sum bit above the carry-in, so it never reaches an output.
  assign unused_p0 = p_bit[0];

  assign new_sum  = p_bit[WIDTH:1] ^ g_grp[WIDTH-1:0];
  assign new_zero = (new_sum == '0);

  assign push = in_valid & in_ready_q;
  assign pop  = (occ != EMPTY) & out_ready;

  // NOTE: every path assigns occ_nxt first, so no latch is inferred in this always_comb.
  always_comb begin
    occ_nxt = occ;
    case (occ)
      EMPTY: if (push) occ_nxt = ONE;
      ONE: begin
        if (push && !pop)      occ_nxt = FULL;
        else if (pop && !push) occ_nxt = EMPTY;
      end
      FULL:    if (pop) occ_nxt = ONE;
      default: occ_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ        <= EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      in_ready_q <= 1'b1;
      op_cnt_q   <= '0;
    end else begin
      occ        <= occ_nxt;
      in_ready_q <= (occ_nxt != FULL);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        op_cnt_q <= op_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: the two entries are reset because the outputs show the head entry even when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_sum[i]  <= '0;
        mem_cout[i] <= 1'b0;
        mem_zero[i] <= 1'b0;
        mem_tag[i]  <= '0;
      end
    end else if (push) begin
      mem_sum[wr_ptr]  <= new_sum;
      mem_cout[wr_ptr] <= g_grp[WIDTH];
      mem_zero[wr_ptr] <= new_zero;
      mem_tag[wr_ptr]  <= in_tag;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (occ != EMPTY);
  assign sum       = mem_sum[rd_ptr];
  assign cout      = mem_cout[rd_ptr];
  assign zero      = mem_zero[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_bk_sum_stage.sv
// Self-checking bench for bk_sum_stage: operands A/B/cin are turned into PG vectors by an
// arithmetic golden model, and results are checked against A+B+cin through a FIFO model.
module tb_bk_sum_stage;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH:0]   p_bit = '0;
  logic [WIDTH:0]   g_grp = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             zero;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] op_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  bk_sum_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .p_bit(p_bit), .g_grp(g_grp), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .zero(zero), .out_tag(out_tag),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected result straight from integer addition.
  function automatic res_t expect_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin, input logic [TAG_W-1:0] tag);
    res_t r;
    logic [WIDTH:0] t;
    t      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.zero = (t[WIDTH-1:0] == '0);
    r.tag  = tag;
    return r;
  endfunction

  // Golden PG: p_bit[k+1] = a[k]^b[k]; g_grp[j] = carry into bit j of the low j bits' sum.
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic [TAG_W-1:0] tag);
    int m, s;
    p_bit[0] = 1'($urandom_range(0, 1));
    for (int k = 0; k < WIDTH; k++) p_bit[k+1] = a[k] ^ b[k];
    for (int j = 0; j <= WIDTH; j++) begin
      m = (1 << j) - 1;
      s = (int'(a) & m) + (int'(b) & m) + int'(cin);
      g_grp[j] = 1'((s >> j) & 1);
    end
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #3;
    rst_n    = 1'b1;
    exp_cnt  = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({sum, cout, zero, out_tag} !== '0) begin errors++;
      $display("FAIL reset_data got sum=%h cout=%b zero=%b tag=%h exp all 0", sum, cout, zero, out_tag); end
    checks++; if (op_cnt !== '0) begin errors++; $display("FAIL reset_op_cnt got %h exp 0", op_cnt); end
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    res_t e;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(8'h0F, 8'h01, 1'b0, 4'h5);
    e = expect_of(8'h0F, 8'h01, 1'b0, 4'h5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if ({sum, cout, zero, out_tag} !== {e.sum, e.cout, e.zero, e.tag}) begin errors++;
      $display("FAIL basic_result got %h/%b/%b/%h exp %h/%b/%b/%h", sum, cout, zero, out_tag, e.sum, e.cout, e.zero, e.tag); end
    @(posedge clk); #1;
    exp_cnt++;
    checks++; if (op_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL basic_op_cnt got %0d exp %0d", op_cnt, exp_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_zero_cout();
    logic [WIDTH-1:0] av [2];
    logic [WIDTH-1:0] bv [2];
    logic             cv [2];
    res_t e;
    av[0] = 8'hFF; bv[0] = 8'h00; cv[0] = 1'b1;
    av[1] = 8'h80; bv[1] = 8'h80; cv[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(av[i], bv[i], cv[i], 4'(i + 7));
      e = expect_of(av[i], bv[i], cv[i], 4'(i + 7));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if ({out_valid, sum, cout, zero, out_tag} !== {1'b1, e.sum, e.cout, e.zero, e.tag}) begin errors++;
        $display("FAIL zero_cout_%0d got v=%b %h/%b/%b/%h exp v=1 %h/%b/%b/%h", i, out_valid, sum, cout, zero, out_tag,
                 e.sum, e.cout, e.zero, e.tag); end
      exp_cnt++;
    end
  endtask

  task automatic test_backpressure();
    res_t ev [3];
    int   got;
    logic pop_now, push_now;
    do_reset();
    out_ready = 1'b0;
    ev[0] = expect_of(8'h11, 8'h22, 1'b0, 4'h1);
    ev[1] = expect_of(8'h33, 8'h44, 1'b1, 4'h2);
    ev[2] = expect_of(8'h55, 8'h66, 1'b0, 4'h3);
    @(posedge clk); #1;
    drive(8'h11, 8'h22, 1'b0, 4'h1);
    @(posedge clk); #1;
    drive(8'h33, 8'h44, 1'b1, 4'h2);
    @(posedge clk); #1;
    drive(8'h55, 8'h66, 1'b0, 4'h3);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    @(posedge clk); #1;
    checks++; if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 4'h1}) begin errors++;
      $display("FAIL bp_hold got ready=%b valid=%b tag=%h exp ready=0 valid=1 tag=1", in_ready, out_valid, out_tag); end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      pop_now  = out_valid;
      push_now = in_valid && in_ready;
      if (pop_now) begin
        checks++; if ({out_tag, sum, cout} !== {ev[got].tag, ev[got].sum, ev[got].cout}) begin errors++;
          $display("FAIL bp_order_%0d got tag=%h sum=%h cout=%b exp tag=%h sum=%h cout=%b", got, out_tag, sum, cout,
                   ev[got].tag, ev[got].sum, ev[got].cout); end
      end
      @(posedge clk); #1;
      if (push_now) in_valid = 1'b0;
      if (pop_now) begin got++; exp_cnt++; end
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got); end
    checks++; if (op_cnt !== 16'd3) begin errors++; $display("FAIL bp_op_cnt got %0d exp 3", op_cnt); end
  endtask

  task automatic test_random(input int n_ops);
    res_t q[$];
    res_t cur, h;
    int   pushed, popped;
    logic acc;
    logic [WIDTH-1:0] a, b;
    logic cin;
    pushed = 0; popped = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 30000 && popped < n_ops; c++) begin
      if (!in_valid && pushed < n_ops && $urandom_range(0, 3) != 0) begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom_range(0, 1));
        drive(a, b, cin, 4'($urandom));
        cur = expect_of(a, b, cin, in_tag);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++; if (in_ready !== (q.size() != 2)) begin errors++;
        $display("FAIL rand_in_ready got %b exp %b (model occ %0d)", in_ready, q.size() != 2, q.size()); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++;
        $display("FAIL rand_out_valid got %b exp %b (model occ %0d)", out_valid, q.size() != 0, q.size()); end
      if (out_valid && out_ready && q.size() != 0) begin
        h = q.pop_front();
        checks++; if ({sum, cout, zero, out_tag} !== {h.sum, h.cout, h.zero, h.tag}) begin errors++;
          $display("FAIL rand_result_%0d got %h/%b/%b/%h exp %h/%b/%b/%h", popped, sum, cout, zero, out_tag,
                   h.sum, h.cout, h.zero, h.tag); end
        popped++;
        exp_cnt++;
      end
      acc = in_valid && in_ready;
      if (acc) begin q.push_back(cur); pushed++; end
      checks++; if (q.size() > 2) begin errors++; $display("FAIL rand_occupancy got %0d exp <=2", q.size()); end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (popped != n_ops) begin errors++; $display("FAIL rand_timeout got %0d exp %0d results", popped, n_ops); end
    @(negedge clk);
    checks++; if (op_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL rand_op_cnt got %0d exp %0d", op_cnt, CNT_W'(exp_cnt)); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(8'hA5, 8'h5A, 1'b0, 4'hA);
    @(posedge clk); #1;
    drive(8'h12, 8'h34, 1'b1, 4'hB);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b01) begin errors++;
      $display("FAIL ar_full got ready=%b valid=%b exp ready=0 valid=1", in_ready, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL ar_flags got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    checks++; if ({op_cnt, sum, out_tag} !== '0) begin errors++;
      $display("FAIL ar_state got cnt=%h sum=%h tag=%h exp 0", op_cnt, sum, out_tag); end
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(8'h01, 8'h01, 1'b0, 4'h9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_valid, sum, out_tag} !== {1'b1, 8'h02, 4'h9}) begin errors++;
      $display("FAIL ar_first_push got v=%b sum=%h tag=%h exp v=1 sum=02 tag=9", out_valid, sum, out_tag); end
    @(posedge clk); #1;
    checks++; if ({out_valid, op_cnt} !== {1'b0, 16'd1}) begin errors++;
      $display("FAIL ar_after_pop got v=%b cnt=%0d exp v=0 cnt=1", out_valid, op_cnt); end
  endtask

  task automatic test_wrap();
    int pops;
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(8'h3C, 8'h03, 1'b0, 4'h4);
    pops = 0;
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) pops++;
      if (pops == 65535) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (op_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h exp ffff", op_cnt); end
    @(posedge clk); #1;
    checks++; if (op_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", op_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cout();
    test_backpressure();
    test_random(2000);
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
